// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants
package uart_pkg;
   localparam int UART_DATA_W       = 8;
   localparam int UART_RXFIFO_DEPTH = 8;
endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - single write port, asynchronous read port storage
// Contents are intentionally not reset.
module uart_fifo_mem #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with edge-captured input and sticky error flags
// Control (edge detect, pointers, count, flags) lives here; storage is uart_fifo_mem.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RXFIFO_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [UART_DATA_W-1:0] rxDataIn,
   input  logic                   rxAvailIn,
   input  logic                   rxErrorIn,
   input  logic                   popIn,
   input  logic                   clrFlagsIn,
   output logic [UART_DATA_W-1:0] dataOut,
   output logic                   emptyOut,
   output logic                   fullOut,
   output logic [CW-1:0]          countOut,
   output logic                   overrunOut,
   output logic                   frameErrOut
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic                   rxAvailQ;
   logic [AW-1:0]          wrPtr;
   logic [AW-1:0]          rdPtr;
   logic [CW-1:0]          count;
   logic                   strobe;
   logic                   push_ok;
   logic                   pop_ok;
   logic                   overrun_set;
   logic                   frame_set;
   logic [UART_DATA_W-1:0] mem_rdata;

   assign emptyOut = (count == '0);
   assign fullOut  = (count == FULL_COUNT);
   assign countOut = count;

   assign strobe = rxAvailIn & ~rxAvailQ;

   // A full FIFO still accepts when a pop frees the head slot in the same cycle.
   assign push_ok     = strobe & ~rxErrorIn & (~fullOut | popIn);
   assign pop_ok      = popIn & ~emptyOut;
   assign overrun_set = strobe & ~rxErrorIn & fullOut & ~popIn;
   assign frame_set   = strobe & rxErrorIn;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxAvailQ <= 1'b1;
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
      end else begin
         rxAvailQ <= rxAvailIn;
         if (push_ok) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop_ok) begin
            rdPtr <= rdPtr + AW'(1);
         end
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overrunOut  <= 1'b0;
         frameErrOut <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrunOut <= 1'b1;
         end else if (clrFlagsIn) begin
            overrunOut <= 1'b0;
         end
         if (frame_set) begin
            frameErrOut <= 1'b1;
         end else if (clrFlagsIn) begin
            frameErrOut <= 1'b0;
         end
      end
   end

   uart_fifo_mem #(
      .DW    (UART_DATA_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok & ~reset),
      .waddr (wrPtr),
      .wdata (rxDataIn),
      .raddr (rdPtr),
      .rdata (mem_rdata)
   );

   assign dataOut = emptyOut ? '0 : mem_rdata;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rxDataIn;
   logic       rxAvailIn;
   logic       rxErrorIn;
   logic       popIn;
   logic       clrFlagsIn;
   logic [7:0] dataOut;
   logic       emptyOut;
   logic       fullOut;
   logic [3:0] countOut;
   logic       overrunOut;
   logic       frameErrOut;

   int checks = 0;
   int failures = 0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .rxDataIn    (rxDataIn),
      .rxAvailIn   (rxAvailIn),
      .rxErrorIn   (rxErrorIn),
      .popIn       (popIn),
      .clrFlagsIn  (clrFlagsIn),
      .dataOut     (dataOut),
      .emptyOut    (emptyOut),
      .fullOut     (fullOut),
      .countOut    (countOut),
      .overrunOut  (overrunOut),
      .frameErrOut (frameErrOut)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic err);
      rxDataIn  = d;
      rxErrorIn = err;
      rxAvailIn = 1'b1;
      step();
      rxAvailIn = 1'b0;
      rxErrorIn = 1'b0;
      step();
   endtask

   task automatic pop();
      popIn = 1'b1;
      step();
      popIn = 1'b0;
   endtask

   task automatic clr_flags();
      clrFlagsIn = 1'b1;
      step();
      clrFlagsIn = 1'b0;
   endtask

   // One strobe/pop slot tracked against the reference queue.
   task automatic cycle_op(input logic do_push, input logic [7:0] d, input logic do_pop);
      logic popped;
      popped = 1'b0;
      if (do_pop && q.size() > 0) begin
         chk("wrap_order", 32'(dataOut), 32'(q[0]));
         void'(q.pop_front());
         popped = 1'b1;
      end
      if (do_push && (q.size() < 8 || popped)) q.push_back(d);
      rxDataIn  = d;
      rxAvailIn = do_push;
      popIn     = do_pop;
      step();
      rxAvailIn = 1'b0;
      popIn     = 1'b0;
      chk("wrap_count", 32'(countOut), 32'(q.size()));
      step();
   endtask

   initial begin
      reset = 1'b1; rxDataIn = 8'h00; rxAvailIn = 1'b0; rxErrorIn = 1'b0;
      popIn = 1'b0; clrFlagsIn = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_empty", 32'(emptyOut), 32'd1);
      chk("rst_full", 32'(fullOut), 32'd0);
      chk("rst_count", 32'(countOut), 32'd0);
      chk("rst_data", 32'(dataOut), 32'h00);
      chk("rst_overrun", 32'(overrunOut), 32'd0);
      chk("rst_frame", 32'(frameErrOut), 32'd0);

      // Long-held level captures exactly once.
      rxDataIn = 8'hA5; rxAvailIn = 1'b1;
      step();
      chk("hold_count_1", 32'(countOut), 32'd1);
      chk("hold_data", 32'(dataOut), 32'hA5);
      repeat (49) step();
      chk("hold_count_50", 32'(countOut), 32'd1);
      rxAvailIn = 1'b0;
      step();
      pop();
      chk("hold_drained", 32'(emptyOut), 32'd1);

      // Fill, overflow, drain in order.
      for (int i = 1; i <= 9; i++) begin
         push(8'(i), 1'b0);
         if (i == 7) chk("fill7_full", 32'(fullOut), 32'd0);
         if (i == 8) chk("fill8_full", 32'(fullOut), 32'd1);
      end
      chk("ovf_count", 32'(countOut), 32'd8);
      chk("ovf_flag", 32'(overrunOut), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         chk("ovf_order", 32'(dataOut), 32'(i));
         pop();
      end
      chk("ovf_empty", 32'(emptyOut), 32'd1);
      chk("ovf_empty_data", 32'(dataOut), 32'h00);
      clr_flags();
      chk("ovf_cleared", 32'(overrunOut), 32'd0);

      // Full FIFO with strobe and pop together.
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
      rxDataIn = 8'h55; rxAvailIn = 1'b1; popIn = 1'b1;
      step();
      rxAvailIn = 1'b0; popIn = 1'b0;
      chk("fullpp_count", 32'(countOut), 32'd8);
      chk("fullpp_overrun", 32'(overrunOut), 32'd0);
      chk("fullpp_head", 32'(dataOut), 32'h11);
      step();
      for (int i = 1; i < 8; i++) begin
         chk("fullpp_order", 32'(dataOut), 32'h10 + 32'(i));
         pop();
      end
      chk("fullpp_last", 32'(dataOut), 32'h55);
      pop();
      chk("fullpp_empty", 32'(emptyOut), 32'd1);

      // Framing error discards the byte.
      push(8'h33, 1'b0);
      push(8'hFF, 1'b1);
      chk("frm_count", 32'(countOut), 32'd1);
      chk("frm_flag", 32'(frameErrOut), 32'd1);
      clr_flags();
      chk("frm_cleared", 32'(frameErrOut), 32'd0);
      rxDataIn = 8'hFF; rxErrorIn = 1'b1; rxAvailIn = 1'b1; clrFlagsIn = 1'b1;
      step();
      rxErrorIn = 1'b0; rxAvailIn = 1'b0; clrFlagsIn = 1'b0;
      chk("frm_set_wins", 32'(frameErrOut), 32'd1);
      step();
      clr_flags();
      chk("frm_head", 32'(dataOut), 32'h33);
      pop();

      // Reset mid-stream with the level already high.
      push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0);
      chk("prerst_count", 32'(countOut), 32'd3);
      rxDataIn = 8'h77; rxAvailIn = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_count", 32'(countOut), 32'd0);
      chk("midrst_empty", 32'(emptyOut), 32'd1);
      chk("midrst_data", 32'(dataOut), 32'h00);
      repeat (3) step();
      chk("midrst_nocap", 32'(countOut), 32'd0);
      rxAvailIn = 1'b0;
      step();
      rxAvailIn = 1'b1;
      step();
      chk("midrst_recap", 32'(countOut), 32'd1);
      chk("midrst_recap_data", 32'(dataOut), 32'h77);
      rxAvailIn = 1'b0;
      step();
      pop();

      // Mixed traffic across the pointer wrap.
      q.delete();
      for (int i = 0; i < 20; i++) cycle_op(1'b1, 8'h80 + 8'(i), (i % 3) != 0);
      while (q.size() > 0) cycle_op(1'b0, 8'h00, 1'b1);
      cycle_op(1'b1, 8'h99, 1'b1);
      chk("emptypp_data", 32'(dataOut), 32'h99);
      cycle_op(1'b0, 8'h00, 1'b1);
      cycle_op(1'b0, 8'h00, 1'b1);
      chk("pop_empty_count", 32'(countOut), 32'd0);
      chk("pop_empty_flag", 32'(emptyOut), 32'd1);
      chk("pop_empty_noerr", 32'(overrunOut | frameErrOut), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..256.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, width of countOut.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use clk as its clock.
REQ-004 reset  input  1  the block SHALL use reset as its reset: synchronous, active-high.
REQ-005 rxDataIn  input  8  received byte from the UART receiver.
REQ-006 rxAvailIn  input  1  receiver data-available level; high while a received byte is held.
REQ-007 rxErrorIn  input  1  receiver framing-error level, sampled with rxDataIn.
REQ-008 popIn  input  1  consumer read strobe.
REQ-009 clrFlagsIn  input  1  clears the sticky flags.
REQ-010 dataOut  output  8  head-of-FIFO byte (show-ahead).
REQ-011 emptyOut  output  1  FIFO holds zero entries.
REQ-012 fullOut  output  1  FIFO holds DEPTH entries.
REQ-013 countOut  output  CW  current entry count, 0..DEPTH.
REQ-014 overrunOut  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-015 frameErrOut  output  1  sticky: a byte was discarded because of rxErrorIn.

Function
REQ-016 rxAvailIn SHALL be registered into rxAvailQ every cycle; capture strobe = rxAvailIn & ~rxAvailQ.
REQ-017 Only one byte SHALL be captured per rxAvailIn rising edge, however long the level stays high.
REQ-018 On a strobe with rxErrorIn=1, the byte SHALL be discarded and frameErrOut SHALL be set at that clock edge.
REQ-019 On a strobe with rxErrorIn=0 and FIFO not full, rxDataIn SHALL be written at wrPtr, wrPtr SHALL advance, and count SHALL increment, all at the same edge.
REQ-020 On a strobe to a full FIFO with popIn=0, the byte SHALL be dropped, FIFO contents SHALL be unchanged, and overrunOut SHALL be set.
REQ-021 A strobe to a full FIFO with popIn=1 in the same cycle SHALL be accepted; count stays DEPTH and overrunOut is not set.
REQ-022 popIn=1 with the FIFO not empty SHALL advance rdPtr and decrement count at the edge.
REQ-023 popIn=1 while empty SHALL be ignored, with no state change and no error.
REQ-024 A push and a pop in the same cycle on an empty FIFO SHALL accept the push and ignore the pop, leaving count=1.
REQ-025 A push and a pop in the same cycle on a non-empty, non-full FIFO SHALL leave count unchanged.
REQ-026 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
REQ-027 dataOut SHALL equal mem[rdPtr] combinationally when not empty, and 8'h00 when empty.
REQ-028 emptyOut, fullOut and countOut SHALL be decoded from the registered count with zero latency.
REQ-029 A captured byte SHALL appear on dataOut in the cycle after the strobe edge, giving 1-cycle latency.
REQ-030 clrFlagsIn=1 SHALL clear both sticky flags; if a flag's set condition occurs in the same cycle, set SHALL win.

Reset
REQ-031 Reset SHALL clear wrPtr, rdPtr and count to 0, making emptyOut=1, fullOut=0, countOut=0 and dataOut=8'h00.
REQ-032 Reset SHALL clear overrunOut and frameErrOut to 0.
REQ-033 Reset SHALL set rxAvailQ=1, so that a byte already presented when reset releases is not captured.
REQ-034 Storage contents SHALL NOT be reset.
REQ-035 Reset SHALL take priority over push, pop and clear in the same cycle, so any mid-stream data is discarded.

Structure
REQ-036 Shared package uart_pkg SHALL hold UART_DATA_W=8 and UART_RXFIFO_DEPTH=8.
REQ-037 Storage SHALL be a sub-module uart_fifo_mem (1 write port, 1 asynchronous read port, no reset), instantiated once.
REQ-038 Control logic (edge detect, pointers, count, flags) SHALL reside in uart_rx_fifo.

Verification
REQ-039 Hold rxAvailIn high for 50 cycles with rxDataIn=8'hA5 -> exactly one entry, countOut=1, dataOut=8'hA5 the cycle after the edge.
REQ-040 Push 8'h01..8'h09 via 9 edges with no pops -> fullOut=1 after the 8th; 9th byte dropped; overrunOut=1; pops return 01..08 in order.
REQ-041 Full FIFO, strobe and popIn in the same cycle with 8'h55 -> countOut stays 8, overrunOut=0, 8'h55 is the last byte popped.
REQ-042 Strobe with rxErrorIn=1 and rxDataIn=8'hFF -> countOut unchanged, frameErrOut=1; clrFlagsIn -> 0 the next cycle.
REQ-043 Push 3 bytes, assert reset for 1 cycle while rxAvailIn=1 -> countOut=0, emptyOut=1, no capture until rxAvailIn falls and rises again.
REQ-044 20 push/pop cycles crossing the pointer wrap -> output order matches a reference queue, and a pop on empty leaves count at 0.
